// File: rtl/context_switch_timer_pkg.sv
// Shared definitions for the preemption timer: handler state encoding and fixed addresses.
package context_switch_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_FIRE   = 2'd2,
        ST_KERNEL = 2'd3
    } ctx_state_t;

    localparam int HANDLER_ADDR    = 1083;
    localparam int RESET_PC        = 256;
    localparam int PC_WIDTH_DEF    = 12;
    localparam int QUANTUM_W_DEF   = 16;
    localparam int DEFAULT_QUANTUM = 100;

    // Branch-class instructions may not be interrupted; the exchange waits for them.
    function automatic logic is_branch(input logic jump, input logic bzero, input logic bnegative);
        return jump | bzero | bnegative;
    endfunction

endpackage

// File: rtl/context_switch_timer_counter.sv
// Loadable quantum down-counter with its quantum register; zero writes clamp to 1 and
// the count never drops below 1.
module ctx_quantum_counter #(
    parameter int                W       = 16,
    parameter logic [W-1:0]      DEFAULT = W'(100)
) (
    input  logic         clock,
    input  logic         resetCPU,
    input  logic         quantum_wr,
    input  logic [W-1:0] quantum_data,
    input  logic         reload,
    input  logic         decrement,
    output logic [W-1:0] count,
    output logic [W-1:0] quantum
);

    logic [W-1:0] quantum_q;
    logic [W-1:0] count_q;
    logic [W-1:0] wr_value;
    logic [W-1:0] reload_value;

    always_comb begin
        wr_value     = (quantum_data == '0) ? W'(1) : quantum_data;
        // A write landing on the reload cycle supplies the new value directly.
        reload_value = quantum_wr ? wr_value : quantum_q;
    end

    always_ff @(posedge clock) begin
        if (resetCPU) begin
            quantum_q <= DEFAULT;
            count_q   <= DEFAULT;
        end else begin
            if (quantum_wr)
                quantum_q <= wr_value;
            if (reload)
                count_q <= reload_value;
            else if (decrement && (count_q > W'(1)))
                count_q <= count_q - W'(1);
        end
    end

    assign count   = count_q;
    assign quantum = quantum_q;

endmodule

// File: rtl/context_switch_timer.sv
// Preemption timer driving the PC's jump_context_exchange input.
// Optional build macro CTX_SWITCH_IRQ_EN adds a level irq input that forces early expiry.
//
// state     | meaning
// ST_IDLE   | timer disarmed, counter holds
// ST_COUNT  | user program running, quantum counting down
// ST_FIRE   | exchange pulse to PC, return address captured
// ST_KERNEL | OS handler running, waiting for ctx_return
module context_switch_timer
    import context_switch_timer_pkg::*;
#(
    parameter int PC_WIDTH        = PC_WIDTH_DEF,
    parameter int QUANTUM_WIDTH   = QUANTUM_W_DEF,
    parameter int DEFAULT_QUANTUM = context_switch_timer_pkg::DEFAULT_QUANTUM
) (
    input  logic                     clock,
    input  logic                     resetCPU,
    input  logic                     HLT,
    input  logic                     jump,
    input  logic                     bzero,
    input  logic                     bnegative,
    input  logic [PC_WIDTH-1:0]      programCounter,
    input  logic                     timer_en,
    input  logic                     quantum_wr,
    input  logic [QUANTUM_WIDTH-1:0] quantum_data,
    input  logic                     ctx_return,
`ifdef CTX_SWITCH_IRQ_EN
    input  logic                     irq,
`endif
    output logic                     jump_context_exchange,
    output logic [PC_WIDTH-1:0]      saved_pc,
    output logic                     ctx_busy,
    output logic [QUANTUM_WIDTH-1:0] quantum_left
);

    ctx_state_t                 state, next_state;
    logic                       reload;
    logic                       decrement;
    logic                       capture;
    logic                       expire_req;
    logic                       irq_req;
    logic [QUANTUM_WIDTH-1:0]   count;
    logic [QUANTUM_WIDTH-1:0]   quantum;
    logic [PC_WIDTH-1:0]        saved_pc_q;

`ifdef CTX_SWITCH_IRQ_EN
    assign irq_req = irq;
`else
    assign irq_req = 1'b0;
`endif

    assign expire_req = irq_req || (count <= QUANTUM_WIDTH'(1));

    ctx_quantum_counter #(
        .W       (QUANTUM_WIDTH),
        .DEFAULT (QUANTUM_WIDTH'(DEFAULT_QUANTUM))
    ) u_counter (
        .clock        (clock),
        .resetCPU     (resetCPU),
        .quantum_wr   (quantum_wr),
        .quantum_data (quantum_data),
        .reload       (reload),
        .decrement    (decrement),
        .count        (count),
        .quantum      (quantum)
    );

    always_comb begin
        next_state = state;
        reload     = 1'b0;
        decrement  = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (timer_en) begin
                    next_state = ST_COUNT;
                    reload     = 1'b1;
                end
            end
            ST_COUNT: begin
                if (!timer_en) begin
                    next_state = ST_IDLE;
                end else if (!HLT) begin
                    if (!expire_req) begin
                        decrement = 1'b1;
                    end else if (!is_branch(jump, bzero, bnegative)) begin
                        next_state = ST_FIRE;
                        capture    = 1'b1;
                    end
                end
            end
            ST_FIRE: begin
                // A halted PC cannot take the jump, so the pulse stays up until it can.
                if (!HLT)
                    next_state = ST_KERNEL;
            end
            ST_KERNEL: begin
                if (ctx_return) begin
                    next_state = ST_COUNT;
                    reload     = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (resetCPU) begin
            state      <= ST_IDLE;
            saved_pc_q <= '0;
        end else begin
            state <= next_state;
            if (capture)
                saved_pc_q <= programCounter + PC_WIDTH'(1);
        end
    end

    assign jump_context_exchange = (state == ST_FIRE);
    assign ctx_busy              = (state == ST_FIRE) || (state == ST_KERNEL);
    assign saved_pc              = saved_pc_q;
    assign quantum_left          = count;

    // Quantum register is only observed through reloads.
    logic unused_quantum;
    assign unused_quantum = ^quantum;

endmodule

// File: tb/tb_context_switch_timer.sv
// Bench for context_switch_timer: directed scenarios plus randomized traffic against a
// cycle-level behavioural model.
module tb_context_switch_timer;

    logic        clock;
    logic        resetCPU;
    logic        HLT, jump, bzero, bnegative;
    logic [11:0] programCounter;
    logic        timer_en, quantum_wr, ctx_return;
    logic [15:0] quantum_data;
    logic        jump_context_exchange, ctx_busy;
    logic [11:0] saved_pc;
    logic [15:0] quantum_left;

    int checks   = 0;
    int failures = 0;

    // model: mode 0 idle, 1 counting, 2 exchange pulse, 3 in handler
    int m_mode, m_q, m_cnt, m_saved;

    context_switch_timer dut (
        .clock                 (clock),
        .resetCPU              (resetCPU),
        .HLT                   (HLT),
        .jump                  (jump),
        .bzero                 (bzero),
        .bnegative             (bnegative),
        .programCounter        (programCounter),
        .timer_en              (timer_en),
        .quantum_wr            (quantum_wr),
        .quantum_data          (quantum_data),
        .ctx_return            (ctx_return),
        .jump_context_exchange (jump_context_exchange),
        .saved_pc              (saved_pc),
        .ctx_busy              (ctx_busy),
        .quantum_left          (quantum_left)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int new_q;
        if (resetCPU) begin
            m_mode = 0; m_q = 100; m_cnt = 100; m_saved = 0;
        end else begin
            new_q = quantum_wr ? ((quantum_data == 0) ? 1 : int'(quantum_data)) : m_q;
            if (m_mode == 0) begin
                if (timer_en) begin m_mode = 1; m_cnt = new_q; end
            end else if (m_mode == 1) begin
                if (!timer_en) m_mode = 0;
                else if (HLT) ;
                else if (m_cnt > 1) m_cnt = m_cnt - 1;
                else if (jump || bzero || bnegative) ;
                else begin
                    m_mode  = 2;
                    m_saved = (int'(programCounter) + 1) % 4096;
                end
            end else if (m_mode == 2) begin
                if (!HLT) m_mode = 3;
            end else begin
                if (ctx_return) begin m_mode = 1; m_cnt = new_q; end
            end
            m_q = new_q;
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        model_step();
        #1;
        check("m_pulse", 32'(jump_context_exchange), 32'(m_mode == 2));
        check("m_busy",  32'(ctx_busy), 32'(m_mode >= 2));
        check("m_qleft", 32'(quantum_left), 32'(m_cnt));
        check("m_saved", 32'(saved_pc), 32'(m_saved));
    endtask

    task automatic run_to_pulse(input string tag, input int budget, output int n);
        n = 0;
        while (!jump_context_exchange && n < budget) begin
            cyc();
            n++;
        end
        if (!jump_context_exchange)
            check({tag, "_timeout"}, 32'(jump_context_exchange), 32'd1);
    endtask

    initial begin
        int n;
        int ql;
        m_mode = 0; m_q = 100; m_cnt = 100; m_saved = 0;
        resetCPU = 1'b1; HLT = 0; jump = 0; bzero = 0; bnegative = 0;
        programCounter = 12'h010; timer_en = 0; quantum_wr = 0; quantum_data = 0; ctx_return = 0;
        cyc(); cyc();
        resetCPU = 1'b0;
        check("rst_qleft", 32'(quantum_left), 32'd100);
        check("rst_pulse", 32'(jump_context_exchange), 32'd0);
        check("rst_busy",  32'(ctx_busy), 32'd0);
        check("rst_saved", 32'(saved_pc), 32'd0);

        quantum_wr = 1; quantum_data = 16'd5;
        cyc();
        quantum_wr = 0;
        timer_en = 1;
        run_to_pulse("q5", 50, n);
        check("q5_latency", 32'(n), 32'd6);
        check("q5_saved", 32'(saved_pc), 32'h011);
        cyc();
        check("q5_busy", 32'(ctx_busy), 32'd1);
        check("q5_pulse_end", 32'(jump_context_exchange), 32'd0);

        ctx_return = 1;
        cyc();
        check("ret_qleft", 32'(quantum_left), 32'd5);
        check("ret_busy", 32'(ctx_busy), 32'd0);
        cyc();
        ctx_return = 0;
        check("ret_in_count", 32'(quantum_left), 32'd4);
        cyc(); cyc(); cyc();
        check("at_one", 32'(quantum_left), 32'd1);

        jump = 1; programCounter = 12'h018;
        cyc();
        check("defer1", 32'(jump_context_exchange), 32'd0);
        bzero = 1; jump = 0;
        cyc();
        check("defer2", 32'(jump_context_exchange), 32'd0);
        check("defer_qleft", 32'(quantum_left), 32'd1);
        bzero = 0; programCounter = 12'h020;
        cyc();
        check("defer_pulse", 32'(jump_context_exchange), 32'd1);
        check("defer_saved", 32'(saved_pc), 32'h021);

        HLT = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("hlt_fire", 32'(jump_context_exchange), 32'd1);
        end
        HLT = 0;
        cyc();
        check("hlt_fire_rel", 32'(jump_context_exchange), 32'd0);
        check("hlt_fire_busy", 32'(ctx_busy), 32'd1);
        ctx_return = 1;
        cyc();
        ctx_return = 0;
        cyc();
        ql = int'(quantum_left);
        HLT = 1;
        for (int i = 0; i < 10; i++) cyc();
        check("hlt_count", 32'(quantum_left), 32'(ql));
        HLT = 0;

        quantum_wr = 1; quantum_data = 16'd8;
        cyc();
        quantum_wr = 0;
        check("wr_no_effect", 32'(quantum_left), 32'(ql - 1));
        run_to_pulse("q8a", 50, n);
        cyc();
        ctx_return = 1;
        cyc();
        ctx_return = 0;
        check("q8_reload", 32'(quantum_left), 32'd8);
        quantum_wr = 1; quantum_data = 16'd0;
        cyc();
        quantum_wr = 0;
        check("wr0_running", 32'(quantum_left), 32'd7);
        run_to_pulse("q8b", 50, n);
        check("q8_latency", 32'(n), 32'd7);
        cyc();
        ctx_return = 1;
        cyc();
        ctx_return = 0;
        check("q0_as_1", 32'(quantum_left), 32'd1);
        programCounter = 12'hFFF;
        cyc();
        check("q1_pulse", 32'(jump_context_exchange), 32'd1);
        check("wrap_saved", 32'(saved_pc), 32'h000);
        cyc();
        resetCPU = 1;
        cyc();
        resetCPU = 0;
        check("rstk_busy", 32'(ctx_busy), 32'd0);
        check("rstk_pulse", 32'(jump_context_exchange), 32'd0);
        check("rstk_qleft", 32'(quantum_left), 32'd100);
        check("rstk_saved", 32'(saved_pc), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            resetCPU       = ($urandom_range(0, 199) == 0);
            HLT            = ($urandom_range(0, 9) == 0);
            jump           = ($urandom_range(0, 9) == 0);
            bzero          = ($urandom_range(0, 14) == 0);
            bnegative      = ($urandom_range(0, 14) == 0);
            programCounter = 12'($urandom);
            timer_en       = ($urandom_range(0, 29) != 0);
            quantum_wr     = ($urandom_range(0, 19) == 0);
            quantum_data   = 16'($urandom_range(0, 10));
            ctx_return     = ($urandom_range(0, 3) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
